// File: rtl/i2cs_wb_pkg.sv
// rtl/i2cs_wb_pkg.sv - shared types and helpers for the i2cs register-bank to Wishbone bridge
package i2cs_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } wb_state_t;

    localparam logic [31:0] RD_ERR_DATA = '1;

    function automatic int word_shift(input int rdw);
        return $clog2(rdw / 8);
    endfunction

    function automatic logic [7:0] word_align(input logic [7:0] addr, input int ws);
        return 8'((addr >> ws) << ws);
    endfunction

endpackage

// File: rtl/i2cs_wb_tmo.sv
// rtl/i2cs_wb_tmo.sv - Wishbone ack-wait timeout counter
module i2cs_wb_tmo #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);

    logic [7:0] cnt;

    // cnt holds (cycles with run high) - 1, so expired fires on the TIMEOUT-th cycle
    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt <= '0;
        end else if (run && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = run & (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/i2cs_wb_bridge.sv
// rtl/i2cs_wb_bridge.sv - i2cs register port to Wishbone master bridge (optional I2CS_WB_TIMEOUT_EN)
module i2cs_wb_bridge
    import i2cs_wb_pkg::*;
#(
    parameter int              RDW       = 32,
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = AW'(32'h3000_0000),
    parameter int              TIMEOUT   = 255
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               WrEn,
    input  logic [7:0]         RdWrAdd,
    input  logic [RDW-1:0]     WrData,
    output logic [RDW-1:0]     RdData,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [AW-1:0]      wbm_adr_o,
    output logic [RDW-1:0]     wbm_dat_o,
    output logic [RDW/8-1:0]   wbm_sel_o,
    input  logic [RDW-1:0]     wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic               busy,
    output logic               err
);

    localparam int WS = word_shift(RDW);
    localparam int IW = 8 - WS;

    wb_state_t      state, state_n;
    logic           wren_q, wr_pend, wr_dirty, rd_pend, addr_vld, addr_vld_n;
    logic [7:0]     wr_addr;
    logic [RDW-1:0] wr_data, rd_data_n;
    logic [IW-1:0]  cur_idx, last_idx, last_idx_n, cyc_idx;
    logic           wr_edge, go_wr, go_rd, bus_fail, bus_end, tmo_expired;

    assign cur_idx   = RdWrAdd[7:WS];
    assign wr_edge   = WrEn & ~wren_q;
    assign bus_fail  = wbm_cyc_o & (wbm_err_i | tmo_expired);
    assign bus_end   = wbm_cyc_o & (wbm_ack_i | wbm_err_i | tmo_expired);
    assign wbm_stb_o = wbm_cyc_o;
    assign busy      = (state != IDLE) | wr_pend | rd_pend;

`ifdef I2CS_WB_TIMEOUT_EN
    i2cs_wb_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (Clk),
        .reset   (Reset),
        .start   (go_wr | go_rd),
        .run     (wbm_cyc_o),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0 & (TIMEOUT > 0);
`endif

    always_comb begin
        state_n = state;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend) begin
                    state_n = WR;
                    go_wr   = 1'b1;
                end else if (rd_pend) begin
                    state_n = RD;
                    go_rd   = 1'b1;
                end
            end
            WR, RD: begin
                if (bus_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A failed read still marks its word fetched so a dead slave cannot cause a retry storm
    always_comb begin
        last_idx_n = last_idx;
        addr_vld_n = addr_vld;
        rd_data_n  = RdData;
        if (state == RD && bus_end) begin
            last_idx_n = cyc_idx;
            addr_vld_n = 1'b1;
            rd_data_n  = bus_fail ? RD_ERR_DATA[RDW-1:0] : wbm_dat_i;
        end else if (state == WR && bus_end && !bus_fail && cyc_idx == cur_idx) begin
            last_idx_n = cur_idx;
            addr_vld_n = 1'b1;
            rd_data_n  = wbm_dat_o;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            wren_q    <= 1'b0;
            wr_pend   <= 1'b0;
            wr_dirty  <= 1'b0;
            rd_pend   <= 1'b0;
            addr_vld  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            last_idx  <= '0;
            cyc_idx   <= '0;
            RdData    <= '0;
            err       <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
        end else begin
            state    <= state_n;
            wren_q   <= WrEn;
            last_idx <= last_idx_n;
            addr_vld <= addr_vld_n;
            RdData   <= rd_data_n;
            rd_pend  <= !addr_vld_n || (cur_idx != last_idx_n);

            // A write edge during an in-flight write (wr_dirty) keeps wr_pend so the new slot is issued too
            if (wr_edge) begin
                wr_addr <= RdWrAdd;
                wr_data <= WrData;
                wr_pend <= 1'b1;
            end else if (state == WR && bus_end && !wr_dirty) begin
                wr_pend <= 1'b0;
            end

            if (go_wr)              wr_dirty <= wr_edge;
            else if (state == WR)   wr_dirty <= wr_dirty | wr_edge;
            else                    wr_dirty <= 1'b0;

            if ((wr_edge && wr_pend) || bus_fail) err <= 1'b1;

            if (go_wr) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= 1'b1;
                wbm_adr_o <= BASE_ADDR + AW'(word_align(wr_addr, WS));
                wbm_dat_o <= wr_data;
                wbm_sel_o <= '1;
                cyc_idx   <= wr_addr[7:WS];
            end else if (go_rd) begin
                wbm_cyc_o <= 1'b1;
                wbm_we_o  <= 1'b0;
                wbm_adr_o <= BASE_ADDR + AW'(word_align(RdWrAdd, WS));
                wbm_sel_o <= '1;
                cyc_idx   <= cur_idx;
            end else if (bus_end) begin
                wbm_cyc_o <= 1'b0;
                wbm_we_o  <= 1'b0;
            end
        end
    end

endmodule
